// File: rtl/sha256_msg_sched_if.sv
// Block-load and schedule-word handshake bundle for the SHA-256 message schedule expander.
// master is the expander side; slave is the loader/round-stage side.
interface sha256_msg_sched_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last;

    modport master (
        input  blk_valid, blk_data, w_ready,
        output blk_ready, w_valid, w_data, w_idx, w_last
    );

    modport slave (
        output blk_valid, blk_data, w_ready,
        input  blk_ready, w_valid, w_data, w_idx, w_last
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule expander: loads one 512-bit block and streams W[0..NUM_WORDS-1]
// through a 16-word sliding window, one word per accepted transfer.
module sha256_msg_sched #(
    parameter int unsigned NUM_WORDS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sha256_msg_sched_if.master    bus,
    output logic                  busy
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    state_t      state, state_nxt;
    logic [31:0] win [16];
    logic [5:0]  t;
    logic        load, xfer;
    logic [31:0] w_new;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // window[0] is W[t]; the new tail word is W[t+16]
    assign w_new = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.blk_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.w_ready) begin
                    xfer = 1'b1;
                    if (t == LAST_IDX) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            t <= '0;
        end else if (load) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= bus.blk_data[32*(15-i) +: 32];
            end
            t <= '0;
        end else if (xfer && (t != LAST_IDX)) begin
            for (int unsigned i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= w_new;
            t       <= t + 6'd1;
        end
    end

    // outputs depend only on registered state, never on w_ready/blk_valid
    assign bus.blk_ready = (state == IDLE);
    assign bus.w_valid   = (state == RUN);
    assign bus.w_data    = win[0];
    assign bus.w_idx     = t;
    assign bus.w_last    = (state == RUN) && (t == LAST_IDX);
    assign busy          = (state == RUN);
endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: a reference W-array model fills a scoreboard
// queue on every block load; each accepted word is popped and compared.
module tb_sha256_msg_sched;
    typedef struct {
        logic [31:0] data;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    int   compared = 0;
    int   mismatched = 0;
    exp_t expq [$];

    sha256_msg_sched_if bus ();

    sha256_msg_sched #(.NUM_WORDS(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic push_block(input logic [511:0] blk);
        logic [31:0] w [64];
        exp_t e;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
        for (int i = 0; i < 64; i++) begin
            e.data = w[i];
            e.idx  = 6'(i);
            e.last = (i == 63);
            expq.push_back(e);
        end
    endtask

    // called at a negedge; returns at the negedge of the first RUN cycle
    task automatic send_block(input logic [511:0] blk);
        int n = 0;
        bus.blk_valid = 1'b1;
        bus.blk_data  = blk;
        while (!bus.blk_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1("blk_ready_wait", bus.blk_ready, 1'b1);
        push_block(blk);
        @(negedge clk);
        bus.blk_valid = 1'b0;
        chk1("first_valid", bus.w_valid, 1'b1);
        chk32("first_idx", {26'b0, bus.w_idx}, 32'd0);
    endtask

    task automatic drain(input int limit, input bit bp, input bit chk_abc, input bit hold);
        int          got = 0;
        int          cyc = 0;
        bit          pstall = 1'b0;
        logic [31:0] pdata = '0;
        logic [5:0]  pidx = '0;
        logic        plast = 1'b0;
        exp_t        e;
        while (got < limit && cyc < 2000) begin
            bus.w_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            chk1("w_valid_run", bus.w_valid, 1'b1);
            chk1("busy_run", busy, 1'b1);
            if (hold) chk1("blk_ready_run", bus.blk_ready, 1'b0);
            if (pstall) begin
                chk32("stall_data", bus.w_data, pdata);
                chk32("stall_idx", {26'b0, bus.w_idx}, {26'b0, pidx});
                chk1("stall_last", bus.w_last, plast);
            end
            if (bus.w_ready && bus.w_valid) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk32("w_data", bus.w_data, e.data);
                    chk32("w_idx", {26'b0, bus.w_idx}, {26'b0, e.idx});
                    chk1("w_last", bus.w_last, e.last);
                    if (chk_abc) begin
                        case (e.idx)
                            6'd0:  chk32("abc_W0", bus.w_data, 32'h61626380);
                            6'd15: chk32("abc_W15", bus.w_data, 32'h00000018);
                            6'd16: chk32("abc_W16", bus.w_data, 32'h61626380);
                            6'd17: chk32("abc_W17", bus.w_data, 32'h000F0000);
                            6'd63: chk32("abc_W63", bus.w_data, 32'h12B1EDEB);
                            default: ;
                        endcase
                    end
                end else begin
                    chk32("sb_underflow", 32'(expq.size()), 32'd1);
                end
                got++;
            end
            pstall = bus.w_valid && !bus.w_ready;
            pdata  = bus.w_data;
            pidx   = bus.w_idx;
            plast  = bus.w_last;
            @(negedge clk);
            cyc++;
        end
        bus.w_ready = 1'b0;
        chk32("drain_count", 32'(got), 32'(limit));
    endtask

    logic [511:0] abc_blk;
    logic [511:0] rnd_blk;

    initial begin
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.w_ready   = 1'b0;

        // 1. asynchronous reset mid-cycle, held, then w_ready in IDLE is ignored
        #7 rst_n = 1'b0;
        #1;
        chk1("rst_blk_ready", bus.blk_ready, 1'b1);
        chk1("rst_w_valid", bus.w_valid, 1'b0);
        chk32("rst_w_data", bus.w_data, 32'h0);
        chk32("rst_w_idx", {26'b0, bus.w_idx}, 32'd0);
        chk1("rst_w_last", bus.w_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk1("rst_hold_blk_ready", bus.blk_ready, 1'b1);
            chk1("rst_hold_w_valid", bus.w_valid, 1'b0);
        end
        rst_n = 1'b1;
        bus.w_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("idle_w_valid", bus.w_valid, 1'b0);
            chk1("idle_busy", busy, 1'b0);
            chk32("idle_w_idx", {26'b0, bus.w_idx}, 32'd0);
        end
        bus.w_ready = 1'b0;

        // 2. abc block, full throughput
        send_block(abc_blk);
        drain(64, 1'b0, 1'b1, 1'b0);
        chk1("post_blk_ready", bus.blk_ready, 1'b1);
        chk1("post_w_valid", bus.w_valid, 1'b0);

        // 3. abc block under random backpressure
        send_block(abc_blk);
        drain(64, 1'b1, 1'b1, 1'b0);

        // 4. second block held pending during RUN
        for (int i = 0; i < 16; i++) rnd_blk[32*i +: 32] = $urandom();
        send_block(abc_blk);
        bus.blk_valid = 1'b1;
        bus.blk_data  = rnd_blk;
        drain(64, 1'b0, 1'b1, 1'b1);
        chk1("gap_blk_ready", bus.blk_ready, 1'b1);
        chk1("gap_w_valid", bus.w_valid, 1'b0);
        send_block(rnd_blk);
        chk32("second_W0", bus.w_data, rnd_blk[511:480]);
        drain(64, 1'b1, 1'b0, 1'b0);

        // 5. reset pulse at w_idx 30
        send_block(abc_blk);
        drain(30, 1'b0, 1'b0, 1'b0);
        chk32("idx_at_30", {26'b0, bus.w_idx}, 32'd30);
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst_w_valid", bus.w_valid, 1'b0);
        chk1("midrst_blk_ready", bus.blk_ready, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("midrst_no_partial", bus.w_valid, 1'b0);
        for (int i = 0; i < 16; i++) rnd_blk[32*i +: 32] = $urandom();
        send_block(rnd_blk);
        drain(64, 1'b1, 1'b0, 1'b0);

        // 6. all-ones block exercises mod-2^32 wrap
        send_block('1);
        drain(64, 1'b0, 1'b0, 1'b0);

        chk32("sb_empty", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
